// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: RV32I opcodes, ALU control codes,
// immediate formats and the small decode helpers built on them.
package id_pkg;

    localparam logic [6:0] OP     = 7'h33;
    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] JALR   = 7'h67;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] AUIPC  = 7'h17;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_ctrl_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_ctrl_e a;
        case (f3)
            3'b000:  a = alt ? ALU_SUB : ALU_ADD;
            3'b001:  a = ALU_SLL;
            3'b010:  a = ALU_SLT;
            3'b011:  a = ALU_SLTU;
            3'b100:  a = ALU_XOR;
            3'b101:  a = alt ? ALU_SRA : ALU_SRL;
            3'b110:  a = ALU_OR;
            default: a = ALU_AND;
        endcase
        return a;
    endfunction

    function automatic logic [31:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] ins);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_stage_pipe_regfile.sv
// Architectural register file: two combinational read ports, one write port,
// x0 hardwired to zero, optional write-through of the same-cycle write.
module regfile #(
    parameter int  XLEN      = 32,
    parameter int  NREG      = 32,
    parameter int  BYPASS_EN = 1,
    localparam int AW        = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   i_rs1,
    input  logic [AW-1:0]   i_rs2,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2,
    input  logic            i_wr,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [XLEN-1:0] i_wr_data
);

    logic [NREG-1:0][XLEN-1:0] mem_q, mem_d;
    logic                      wr_en;

    assign wr_en = i_wr && (i_wr_addr != '0);

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[i_wr_addr] = i_wr_data;
    end

    always_comb begin
        o_rd1 = (i_rs1 == '0) ? '0 : mem_q[i_rs1];
        o_rd2 = (i_rs2 == '0) ? '0 : mem_q[i_rs2];
        if ((BYPASS_EN != 0) && wr_en && (i_wr_addr == i_rs1)) o_rd1 = i_wr_data;
        if ((BYPASS_EN != 0) && wr_en && (i_wr_addr == i_rs2)) o_rd2 = i_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage: decodes one instruction per cycle into an ID/EX register
// with valid/ready handshake, flush, load-use bubble and illegal flagging.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int  XLEN      = 32,
    parameter int  NREG      = 32,
    parameter int  BYPASS_EN = 1,
    localparam int AW        = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_wr,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [XLEN-1:0] i_write_data,
    input  logic            i_flush,
    input  logic            i_ex_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_RS1E,
    output logic [XLEN-1:0] o_RS2E,
    output logic [XLEN-1:0] o_ImmE,
    output logic [6:0]      o_OpE,
    output logic [2:0]      o_Func3E,
    output logic [3:0]      o_ALUCtrlE,
    output logic [AW-1:0]   o_RdE,
    output logic [XLEN-1:0] o_PcE,
    output logic            o_IllegalE
);

    localparam logic [5:0] NREG_W = 6'(NREG);

    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic [4:0]      rs1_f, rs2_f, rd_f;
    imm_fmt_e        fmt;
    alu_ctrl_e       alu;
    logic            known, use_rs1, use_rs2, has_rd, f7_bad, reg_bad, illegal;
    logic [XLEN-1:0] rd1, rd2, imm_x;
    logic            ld, haz;

    logic            valid_q, valid_d, ill_q, ill_d;
    logic [6:0]      op_q, op_d;
    logic [2:0]      f3_q, f3_d;
    logic [3:0]      alu_q, alu_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [XLEN-1:0] imm_q, imm_d, pc_q, pc_d, rs1v_q, rs1v_d, rs2v_q, rs2v_d;

    assign opc   = i_instr[6:0];
    assign rd_f  = i_instr[11:7];
    assign f3    = i_instr[14:12];
    assign rs1_f = i_instr[19:15];
    assign rs2_f = i_instr[24:20];
    assign f7    = i_instr[31:25];

    regfile #(.XLEN(XLEN), .NREG(NREG), .BYPASS_EN(BYPASS_EN)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .i_rs1    (rs1_f[AW-1:0]),
        .i_rs2    (rs2_f[AW-1:0]),
        .o_rd1    (rd1),
        .o_rd2    (rd2),
        .i_wr     (i_wr),
        .i_wr_addr(i_wr_addr),
        .i_wr_data(i_write_data)
    );

    always_comb begin
        fmt     = IMM_NONE;
        alu     = ALU_ADD;
        known   = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        has_rd  = 1'b1;
        f7_bad  = 1'b0;
        case (opc)
            OP: begin
                use_rs2 = 1'b1;
                alu     = alu_from_f3(f3, f7[5]);
                f7_bad  = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OP_IMM: begin
                fmt    = IMM_I;
                alu    = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
                // funct7 only exists for the shift forms; elsewhere it is immediate
                f7_bad = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                         ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
            end
            LOAD, JALR: fmt = IMM_I;
            STORE: begin
                fmt     = IMM_S;
                use_rs2 = 1'b1;
                has_rd  = 1'b0;
            end
            BRANCH: begin
                fmt     = IMM_B;
                use_rs2 = 1'b1;
                has_rd  = 1'b0;
                alu     = ALU_SUB;
            end
            LUI: begin
                fmt     = IMM_U;
                use_rs1 = 1'b0;
                alu     = ALU_PASSB;
            end
            AUIPC: begin
                fmt     = IMM_U;
                use_rs1 = 1'b0;
            end
            JAL: begin
                fmt     = IMM_J;
                use_rs1 = 1'b0;
            end
            default: begin
                known  = 1'b0;
                has_rd = 1'b0;
            end
        endcase
        reg_bad = (use_rs1 && ({1'b0, rs1_f} >= NREG_W)) ||
                  (use_rs2 && ({1'b0, rs2_f} >= NREG_W)) ||
                  (has_rd  && ({1'b0, rd_f}  >= NREG_W));
        illegal = !known || (i_instr[1:0] != 2'b11) || f7_bad || reg_bad;
    end

    assign imm_x = XLEN'($signed(gen_imm(fmt, i_instr)));

    // Load-use: the producing load sits in ID/EX and its data is not yet available
    assign ld  = i_ex_ready || !valid_q;
    assign haz = valid_q && (op_q == LOAD) && (rd_q != '0) && i_valid &&
                 ((use_rs1 && (rs1_f == 5'(rd_q))) || (use_rs2 && (rs2_f == 5'(rd_q))));
    assign o_ready = ld && !haz && !i_flush;

    always_comb begin
        valid_d = valid_q;
        ill_d   = ill_q;
        op_d    = op_q;
        f3_d    = f3_q;
        alu_d   = alu_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        rs1v_d  = rs1v_q;
        rs2v_d  = rs2v_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (ld && haz) begin
            valid_d = 1'b0;
        end else if (ld && i_valid) begin
            valid_d = 1'b1;
            ill_d   = illegal;
            op_d    = opc;
            f3_d    = f3;
            alu_d   = illegal ? ALU_ADD : alu;
            rd_d    = (illegal || !has_rd) ? '0 : rd_f[AW-1:0];
            imm_d   = imm_x;
            pc_d    = i_pc;
            rs1v_d  = rd1;
            rs2v_d  = rd2;
        end else if (ld) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ill_q   <= 1'b0;
            op_q    <= '0;
            f3_q    <= '0;
            alu_q   <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            rs1v_q  <= '0;
            rs2v_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ill_q   <= ill_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            rs1v_q  <= rs1v_d;
            rs2v_q  <= rs2v_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_RS1E     = rs1v_q;
    assign o_RS2E     = rs2v_q;
    assign o_ImmE     = imm_q;
    assign o_OpE      = op_q;
    assign o_Func3E   = f3_q;
    assign o_ALUCtrlE = alu_q;
    assign o_RdE      = rd_q;
    assign o_PcE      = pc_q;
    assign o_IllegalE = ill_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: decode table, directed pipeline corner cases and a
// randomized run against a transaction-level reference model.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst, i_valid, i_wr, i_flush, i_ex_ready;
    logic [31:0] i_instr, i_pc, i_write_data;
    logic [4:0]  i_wr_addr;

    logic        o_ready, o_valid, o_IllegalE;
    logic [31:0] o_RS1E, o_RS2E, o_ImmE, o_PcE;
    logic [6:0]  o_OpE;
    logic [2:0]  o_Func3E;
    logic [3:0]  o_ALUCtrlE;
    logic [4:0]  o_RdE;

    logic        e_ready, e_valid, e_IllegalE;
    logic [31:0] e_RS1E, e_RS2E, e_ImmE, e_PcE;
    logic [6:0]  e_OpE;
    logic [2:0]  e_Func3E;
    logic [3:0]  e_ALUCtrlE;
    logic [3:0]  e_RdE;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .NREG(32), .BYPASS_EN(1)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_instr(i_instr),
        .i_pc(i_pc), .i_wr(i_wr), .i_wr_addr(i_wr_addr), .i_write_data(i_write_data),
        .i_flush(i_flush), .i_ex_ready(i_ex_ready), .o_valid(o_valid), .o_RS1E(o_RS1E),
        .o_RS2E(o_RS2E), .o_ImmE(o_ImmE), .o_OpE(o_OpE), .o_Func3E(o_Func3E),
        .o_ALUCtrlE(o_ALUCtrlE), .o_RdE(o_RdE), .o_PcE(o_PcE), .o_IllegalE(o_IllegalE)
    );

    // RV32E flavour without write-through, driven by the same inputs
    id_stage_pipe #(.XLEN(32), .NREG(16), .BYPASS_EN(0)) dut_e (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(e_ready), .i_instr(i_instr),
        .i_pc(i_pc), .i_wr(i_wr), .i_wr_addr(i_wr_addr[3:0]), .i_write_data(i_write_data),
        .i_flush(i_flush), .i_ex_ready(i_ex_ready), .o_valid(e_valid), .o_RS1E(e_RS1E),
        .o_RS2E(e_RS2E), .o_ImmE(e_ImmE), .o_OpE(e_OpE), .o_Func3E(e_Func3E),
        .o_ALUCtrlE(e_ALUCtrlE), .o_RdE(e_RdE), .o_PcE(e_PcE), .o_IllegalE(e_IllegalE)
    );

    typedef struct packed {
        logic        v, ill, u1, u2;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic [31:0] imm, pc, rs1v, rs2v;
    } idex_t;

    idex_t       m;
    logic [31:0] regs [32];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic uses_rs1(input logic [31:0] ins);
        return !(ins[6:0] inside {7'h37, 7'h17, 7'h6F});
    endfunction

    function automatic logic uses_rs2(input logic [31:0] ins);
        return ins[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic idex_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [31:0] a, input logic [31:0] b);
        idex_t      r;
        logic [3:0] tbl [8];
        logic [6:0] f7;
        logic [2:0] f3;
        tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        r = '0;
        f3 = ins[14:12];
        f7 = ins[31:25];
        r.v = 1'b1; r.op = ins[6:0]; r.f3 = f3; r.pc = pc; r.rs1v = a; r.rs2v = b;
        r.rd = ins[11:7]; r.u1 = uses_rs1(ins); r.u2 = uses_rs2(ins);
        case (r.op)
            7'h33: begin
                r.alu = tbl[f3];
                if (f7 == 7'h20 && f3 == 3'd0) r.alu = 4'd1;
                if (f7 == 7'h20 && f3 == 3'd5) r.alu = 4'd7;
                r.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            7'h13: begin
                r.imm = {{20{ins[31]}}, ins[31:20]};
                r.alu = tbl[f3];
                if (f3 == 3'd5 && f7 == 7'h20) r.alu = 4'd7;
                r.ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            end
            7'h03, 7'h67: r.imm = {{20{ins[31]}}, ins[31:20]};
            7'h23: begin r.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; r.rd = 5'd0; end
            7'h63: begin
                r.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                r.alu = 4'd1; r.rd = 5'd0;
            end
            7'h37: begin r.imm = {ins[31:12], 12'b0}; r.alu = 4'd10; end
            7'h17: r.imm = {ins[31:12], 12'b0};
            7'h6F: r.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: r.ill = 1'b1;
        endcase
        if (r.ill) begin r.alu = 4'd0; r.rd = 5'd0; end
        return r;
    endfunction

    task automatic compare_state();
        chk("valid", 64'(o_valid), 64'(m.v));
        if (m.v) begin
            chk("op", 64'(o_OpE), 64'(m.op));
            chk("f3", 64'(o_Func3E), 64'(m.f3));
            chk("alu", 64'(o_ALUCtrlE), 64'(m.alu));
            chk("rd", 64'(o_RdE), 64'(m.rd));
            chk("pc", 64'(o_PcE), 64'(m.pc));
            chk("illegal", 64'(o_IllegalE), 64'(m.ill));
            if (!m.ill) chk("imm", 64'(o_ImmE), 64'(m.imm));
            if (!m.ill && m.u1) chk("rs1v", 64'(o_RS1E), 64'(m.rs1v));
            if (!m.ill && m.u2) chk("rs2v", 64'(o_RS2E), 64'(m.rs2v));
        end
    endtask

    function automatic logic [31:0] rd_reg(input logic [4:0] rs, input logic wr,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (rs == 5'd0) return 32'd0;
        if (wr && wa == rs) return wd;
        return regs[rs];
    endfunction

    // One clock: drive at negedge, check ready pre-edge, check ID/EX post-edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                        input logic fl, input logic exr, output logic rdy);
        logic ld, haz;
        @(negedge clk);
        i_valid = v; i_instr = ins; i_pc = pc; i_wr = wr; i_wr_addr = wa;
        i_write_data = wd; i_flush = fl; i_ex_ready = exr;
        #1;
        ld  = exr || !m.v;
        haz = m.v && m.op == 7'h03 && m.rd != 5'd0 && v &&
              ((uses_rs1(ins) && ins[19:15] == m.rd) || (uses_rs2(ins) && ins[24:20] == m.rd));
        rdy = o_ready;
        chk("ready", 64'(o_ready), 64'(ld && !haz && !fl));
        if (fl || (ld && haz)) m.v = 1'b0;
        else if (ld && v) m = ref_decode(ins, pc, rd_reg(ins[19:15], wr, wa, wd), rd_reg(ins[24:20], wr, wa, wd));
        else if (ld) m.v = 1'b0;
        if (wr && wa != 5'd0) regs[wa] = wd;
        @(posedge clk);
        #1;
        compare_state();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i_valid = 1'b0; i_wr = 1'b0; i_flush = 1'b0; i_ex_ready = 1'b1;
        i_instr = '0; i_pc = '0; i_wr_addr = '0; i_write_data = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m = '0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9];
        logic [31:0] r;
        int          sel;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        r = $urandom;
        sel = $urandom_range(0, 11);
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        r[11:7]  = 5'($urandom_range(0, 7));
        if (sel < 9) begin
            r[6:0] = ops[sel];
            if (r[6:0] inside {7'h33, 7'h13}) begin
                case ($urandom_range(0, 3))
                    0: r[31:25] = 7'h00;
                    1: r[31:25] = 7'h20;
                    default: ;
                endcase
            end
        end
        return r;
    endfunction

    typedef struct {
        logic [31:0] ins, pc, imm;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        ill, chk_imm;
    } vec_t;

    vec_t tbl [12];
    logic rdy;

    initial begin
        tbl[0]  = '{32'h7FF00293, 32'h10, 32'h000007FF, 4'd0,  5'd5,  7'h13, 3'd0, 1'b0, 1'b1};
        tbl[1]  = '{32'hFE5FF3EF, 32'h40, 32'hFFFFFFE4, 4'd0,  5'd7,  7'h6F, 3'd7, 1'b0, 1'b1};
        tbl[2]  = '{32'h0063D863, 32'h44, 32'h00000010, 4'd1,  5'd0,  7'h63, 3'd5, 1'b0, 1'b1};
        tbl[3]  = '{32'h123450B7, 32'h48, 32'h12345000, 4'd10, 5'd1,  7'h37, 3'd5, 1'b0, 1'b1};
        tbl[4]  = '{32'h00512423, 32'h4C, 32'h00000008, 4'd0,  5'd0,  7'h23, 3'd2, 1'b0, 1'b1};
        tbl[5]  = '{32'h402081B3, 32'h50, 32'h00000000, 4'd1,  5'd3,  7'h33, 3'd0, 1'b0, 1'b1};
        tbl[6]  = '{32'h40325213, 32'h54, 32'h00000403, 4'd7,  5'd4,  7'h13, 3'd5, 1'b0, 1'b1};
        tbl[7]  = '{32'h02208033, 32'h58, 32'h00000000, 4'd0,  5'd0,  7'h33, 3'd0, 1'b1, 1'b0};
        tbl[8]  = '{32'h00000000, 32'h5C, 32'h00000000, 4'd0,  5'd0,  7'h00, 3'd0, 1'b1, 1'b0};
        tbl[9]  = '{32'h80000517, 32'h60, 32'h80000000, 4'd0,  5'd10, 7'h17, 3'd0, 1'b0, 1'b1};
        tbl[10] = '{32'h40301093, 32'h64, 32'h00000000, 4'd0,  5'd0,  7'h13, 3'd1, 1'b1, 1'b0};
        tbl[11] = '{32'hFFC280E7, 32'h68, 32'hFFFFFFFC, 4'd0,  5'd1,  7'h67, 3'd0, 1'b0, 1'b1};

        do_reset();
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_imm", 64'(o_ImmE), 64'd0);
        chk("rst_rs1", 64'(o_RS1E), 64'd0);
        chk("rst_rd", 64'(o_RdE), 64'd0);
        chk("rst_pc", 64'(o_PcE), 64'd0);
        chk("rst_ill", 64'(o_IllegalE), 64'd0);

        // same-cycle write of x3 while addi x7,x3,0 reads it
        step(1'b1, 32'h00018393, 32'h0, 1'b1, 5'd3, 32'hAA, 1'b0, 1'b1, rdy);
        chk("bypass_on", 64'(o_RS1E), 64'hAA);
        chk("bypass_off", 64'(e_RS1E), 64'h0);
        step(1'b1, 32'h00018393, 32'h4, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, rdy);
        chk("after_wr_e", 64'(e_RS1E), 64'hAA);

        // add x20,x1,x2: legal on RV32I, illegal on RV32E
        step(1'b1, 32'h00208A33, 32'h8, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, rdy);
        chk("rv32e_ill", 64'(e_IllegalE), 64'd1);
        chk("rv32e_rd", 64'(e_RdE), 64'd0);
        chk("rv32i_rd", 64'(o_RdE), 64'd20);

        // x0 ignores writes, then add x6,x6,x5 with x5=0x7FF, x6=3
        step(1'b0, 32'h0, 32'h0, 1'b1, 5'd0, 32'h55, 1'b0, 1'b1, rdy);
        step(1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h7FF, 1'b0, 1'b1, rdy);
        step(1'b0, 32'h0, 32'h0, 1'b1, 5'd6, 32'h3, 1'b0, 1'b1, rdy);
        step(1'b1, 32'h00530333, 32'h100, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, rdy);
        chk("add_rs1", 64'(o_RS1E), 64'h3);
        chk("add_rs2", 64'(o_RS2E), 64'h7FF);
        chk("add_alu", 64'(o_ALUCtrlE), 64'd0);
        chk("add_op", 64'(o_OpE), 64'h33);
        step(1'b1, 32'h00000033, 32'h104, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, rdy);
        chk("x0_rs1", 64'(o_RS1E), 64'h0);

        for (int i = 0; i < 12; i++) begin
            step(1'b1, tbl[i].ins, tbl[i].pc, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, rdy);
            chk($sformatf("tbl%0d_valid", i), 64'(o_valid), 64'd1);
            chk($sformatf("tbl%0d_op", i), 64'(o_OpE), 64'(tbl[i].op));
            chk($sformatf("tbl%0d_f3", i), 64'(o_Func3E), 64'(tbl[i].f3));
            chk($sformatf("tbl%0d_alu", i), 64'(o_ALUCtrlE), 64'(tbl[i].alu));
            chk($sformatf("tbl%0d_rd", i), 64'(o_RdE), 64'(tbl[i].rd));
            chk($sformatf("tbl%0d_pc", i), 64'(o_PcE), 64'(tbl[i].pc));
            chk($sformatf("tbl%0d_ill", i), 64'(o_IllegalE), 64'(tbl[i].ill));
            if (tbl[i].chk_imm) chk($sformatf("tbl%0d_imm", i), 64'(o_ImmE), 64'(tbl[i].imm));
        end

        // load-use: lw x5,0(x0) then add x6,x6,x5 -> one bubble
        step(1'b1, 32'h00002283, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, rdy);
        chk("lw_op", 64'(o_OpE), 64'h03);
        step(1'b1, 32'h00530333, 32'h204, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, rdy);
        chk("lu_ready", 64'(rdy), 64'd0);
        chk("lu_bubble", 64'(o_valid), 64'd0);
        step(1'b1, 32'h00530333, 32'h204, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, rdy);
        chk("lu_ready2", 64'(rdy), 64'd1);
        chk("lu_issue", 64'(o_valid), 64'd1);
        chk("lu_pc", 64'(o_PcE), 64'h204);

        // stall for 3 cycles, then flush with a concurrent input
        step(1'b1, 32'h7FF00293, 32'h300, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, rdy);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h00530333, 32'h304, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, rdy);
            chk("stall_ready", 64'(rdy), 64'd0);
            chk("stall_valid", 64'(o_valid), 64'd1);
            chk("stall_imm", 64'(o_ImmE), 64'h7FF);
            chk("stall_pc", 64'(o_PcE), 64'h300);
        end
        step(1'b1, 32'h00530333, 32'h308, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, rdy);
        chk("flush_ready", 64'(rdy), 64'd0);
        chk("flush_valid", 64'(o_valid), 64'd0);
        step(1'b0, 32'h0, 32'h30C, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, rdy);
        chk("flush_drop", 64'(o_valid), 64'd0);

        // reset during a stall loses the held instruction
        step(1'b1, 32'h7FF00293, 32'h400, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, rdy);
        step(1'b1, 32'h00530333, 32'h404, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, rdy);
        do_reset();
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_pc", 64'(o_PcE), 64'd0);

        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
